// File: rtl/nibble_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : nibble_serial_adder
// Brief    : WIDTH-bit add/sub computed one nibble per cycle through a 4-bit CLA slice.
// Revision : 1.0 - initial release
// ============================================================================
module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] z_q;
    logic             cout_q;
    logic             ovf_q;
    logic             zero_q;

    logic [3:0]       a_nib;
    logic [3:0]       b_nib;
    logic [3:0]       g;
    logic [3:0]       p;
    logic [4:0]       c;
    logic [3:0]       sum;
    logic [WIDTH-1:0] z_d;
    logic             last;

    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int k = 0; k < NIB; k++) begin
            if (cnt_q == CW'(k)) begin
                a_nib = a_q[4*k +: 4];
                b_nib = b_q[4*k +: 4];
            end
        end
    end

    // Generate/propagate lookahead slice; c[3] is kept for the overflow flag.
    always_comb begin
        g    = a_nib & b_nib;
        p    = a_nib ^ b_nib;
        c[0] = carry_q;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        sum  = p ^ c[3:0];
    end

    always_comb begin
        z_d = z_q;
        for (int k = 0; k < NIB; k++) begin
            if (cnt_q == CW'(k)) begin
                z_d[4*k +: 4] = sum;
            end
        end
        last = (cnt_q == CW'(NIB - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            z_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= x;
                        b_q     <= sub ? ~y : y;
                        carry_q <= sub ? 1'b1 : cin;
                        cnt_q   <= '0;
                        z_q     <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    z_q     <= z_d;
                    carry_q <= c[4];
                    cnt_q   <= cnt_q + CW'(1);
                    if (last) begin
                        cout_q  <= c[4];
                        ovf_q   <= c[3] ^ c[4];
                        zero_q  <= (z_d == '0);
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = rst_n & (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign z         = z_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule
`default_nettype wire

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Multi-cycle wide adder/subtractor built around one 4-bit carry-lookahead slice.
- Captures WIDTH-bit operands with a valid/ready handshake, then adds one nibble per cycle, LSB nibble first.
- Carry is registered between nibbles; the full result, flags and carry-out are presented on an output valid/ready handshake.
- Sits directly upstream of the 4-bit CLA slice: it sequences operands into the slice and consumes the slice's sum and carry-out.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of 4, minimum 4.
- NIB, WIDTH/4 (derived, not overridable), number of nibble cycles.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands and mode valid
- in_ready  output  1  block can accept operands
- x  input  WIDTH  operand A
- y  input  WIDTH  operand B
- cin  input  1  carry-in for add mode; ignored when sub=1
- sub  input  1  1 = compute x - y
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- z  output  WIDTH  sum/difference
- cout  output  1  carry-out of the MSB (no-borrow flag in sub mode)
- ovf  output  1  two's-complement overflow
- zero  output  1  z == 0

Behaviour:
- Reset (async, rst_n=0): state=IDLE, nibble counter=0, carry reg=0, all operand regs cleared.
  - Outputs: z=0, cout=0, ovf=0, zero=0, out_valid=0, in_ready=1 (combinational from IDLE once reset releases; 0 while rst_n=0).
- Reset mid-operation aborts the operation; no partial result is ever flagged valid.
- FSM states: IDLE, RUN, DONE.
  - IDLE: in_ready=1. On in_valid & in_ready at an edge:
    - capture x, and y (or ~y when sub=1);
    - carry reg = (sub ? 1 : cin), counter=0, z cleared; go to RUN.
  - RUN: in_ready=0, out_valid=0. Each edge:
    - nibble k = counter: z[4k+3:4k] = A[k] + B[k] + carry;
    - carry reg = nibble carry-out; counter++.
    - When counter == NIB-1, after this update go to DONE, and at the same edge:
      - cout = nibble carry-out;
      - ovf = (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1);
      - zero = (final z == 0).
  - DONE: out_valid=1; z, cout, ovf and zero are held stable. On out_valid & out_ready at an edge, go to IDLE.
    - out_valid drops and in_ready rises the following cycle.
    - z and the flags keep their last values until the next acceptance.
- Latency: out_valid rises exactly NIB clock edges after the accepting edge (4 edges for WIDTH=16).
  - Minimum issue interval: NIB+2 cycles (one IDLE cycle between operations); no pipelining.
- Operand changes on x/y/cin/sub while not in IDLE are ignored. in_valid outside IDLE has no effect.
- out_ready asserted outside DONE has no effect. Backpressure in DONE may last indefinitely.
- Arithmetic is modulo 2^WIDTH.
  - Add mode: cout = unsigned carry.
  - Sub mode: cout=1 means no borrow (x >= y unsigned).
- The nibble adder uses generate/propagate lookahead:
  - c[i+1] = g[i] | p[i]&c[i];
  - ovf uses the internal c[3] of the last nibble XOR its carry-out.
- WIDTH=4 degenerates to one RUN cycle; all rules still apply.

Test Plan:
- Basic add, WIDTH=16:
  - Stimulus: x=0x000B, y=0x0002, cin=0, sub=0.
  - Response: out_valid exactly 4 edges after acceptance; z=0x000D, cout=0, ovf=0, zero=0.
- Wrap-around:
  - Stimulus: x=0xFFFF, y=0x0001, cin=0.
  - Response: z=0x0000, cout=1, zero=1, ovf=0.
- Carry-in path:
  - Stimulus: x=0x0FFF, y=0x0000, cin=1.
  - Response: z=0x1000, cout=0; the carry ripples across 3 nibble cycles.
- Signed overflow:
  - Stimulus: x=0x7FFF, y=0x0001, add.
  - Response: z=0x8000, ovf=1, cout=0.
- Subtract:
  - Stimulus: x=0x0005, y=0x0007, sub=1, cin=1 (ignored).
  - Response: z=0xFFFE, cout=0, ovf=0.
  - Stimulus: x=0x8000, y=0x0001, sub=1.
  - Response: z=0x7FFF, ovf=1, cout=1.
- Handshake and reset:
  - Stimulus: hold out_ready=0 for 3 cycles in DONE.
  - Response: z and flags stable, in_ready=0; changing x/y during RUN does not alter the result.
  - Stimulus: assert rst_n=0 on the 2nd RUN cycle.
  - Response: outputs go to 0 immediately, out_valid never pulses, in_ready=1 after release.
